div_operand_ctrl: RTL and testbench

DIV_OPERAND_CTRL -- requirements
Module: div_operand_ctrl

---
 rtl/div_operand_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_div_operand_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_ctrl.sv
// div_operand_ctrl: signed/unsigned operand conditioning and result sign fix-up around an unsigned divider core.
// Define DIV_RESULT_REUSE_EN to keep the last core result and skip the core on a repeated operand pair.
module div_operand_ctrl #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [DIV_WIDTH-1:0]         issue_rs1,
    input  logic [DIV_WIDTH-1:0]         issue_rs2,
    input  logic [1:0]                   issue_op,
    input  logic [3:0]                   issue_id,
    output logic                         core_start,
    output logic [DIV_WIDTH-1:0]         core_dividend,
    output logic [DIV_WIDTH-1:0]         core_divisor,
    output logic [$clog2(DIV_WIDTH)-1:0] core_dividend_CLZ,
    output logic [$clog2(DIV_WIDTH)-1:0] core_divisor_CLZ,
    input  logic                         core_done,
    input  logic [DIV_WIDTH-1:0]         core_quotient,
    input  logic [DIV_WIDTH-1:0]         core_remainder,
    output logic                         wb_valid,
    input  logic                         wb_ack,
    output logic [DIV_WIDTH-1:0]         wb_data,
    output logic [3:0]                   wb_id
);
    localparam int LW = $clog2(DIV_WIDTH);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, wb_data_q, wb_data_d;
    logic [LW-1:0]        dvd_clz_q, dvd_clz_d, dvs_clz_q, dvs_clz_d;
    logic                 neg1_q, neg1_d, neg2_q, neg2_d, rem_q, rem_d, done_q, done_d;
    logic [3:0]           id_q, id_d;
    logic                 sgn, n1, n2, ovf, dz;
    logic [DIV_WIDTH-1:0] a1, a2;
`ifdef DIV_RESULT_REUSE_EN
    logic [DIV_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, c_rs1_q, c_rs1_d, c_rs2_q, c_rs2_d;
    logic [DIV_WIDTH-1:0] c_quo_q, c_quo_d, c_rem_q, c_rem_d;
    logic                 sgn_q, sgn_d, c_sgn_q, c_sgn_d, c_vld_q, c_vld_d;
`endif

    // Zero saturates to DIV_WIDTH-1, the same count as a lone LSB.
    function automatic logic [LW-1:0] clz(input logic [DIV_WIDTH-1:0] v);
        clz = LW'(DIV_WIDTH - 1);
        for (int i = 0; i < DIV_WIDTH; i++) if (v[i]) clz = LW'(DIV_WIDTH - 1 - i);
    endfunction

    function automatic logic [DIV_WIDTH-1:0] fix(input logic [DIV_WIDTH-1:0] q, r, input logic s1, s2, rem);
        return rem ? (s1 ? -r : r) : ((s1 ^ s2) ? -q : q);
    endfunction

    assign sgn = ~issue_op[0];
    assign n1  = sgn & issue_rs1[DIV_WIDTH-1];
    assign n2  = sgn & issue_rs2[DIV_WIDTH-1];
    assign a1  = n1 ? -issue_rs1 : issue_rs1;
    assign a2  = n2 ? -issue_rs2 : issue_rs2;
    assign dz  = issue_rs2 == '0;
    assign ovf = sgn && issue_rs1 == {1'b1, {(DIV_WIDTH-1){1'b0}}} && &issue_rs2;

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        dvd_clz_d = dvd_clz_q;
        dvs_clz_d = dvs_clz_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        rem_d     = rem_q;
        done_d    = done_q;
        id_d      = id_q;
        wb_data_d = wb_data_q;
`ifdef DIV_RESULT_REUSE_EN
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        sgn_d   = sgn_q;
        c_rs1_d = c_rs1_q;
        c_rs2_d = c_rs2_q;
        c_sgn_d = c_sgn_q;
        c_quo_d = c_quo_q;
        c_rem_d = c_rem_q;
        c_vld_d = c_vld_q;
`endif
        case (state_q)
            IDLE: if (issue_valid) begin
                dvd_d     = a1;
                dvs_d     = a2;
                dvd_clz_d = clz(a1);
                dvs_clz_d = clz(a2);
                neg1_d    = n1;
                neg2_d    = n2;
                rem_d     = issue_op[1];
                id_d      = issue_id;
                done_d    = 1'b0;
                state_d   = (dz || ovf) ? RESULT : START;
                wb_data_d = dz ? (issue_op[1] ? issue_rs1 : '1) : (issue_op[1] ? '0 : issue_rs1);
`ifdef DIV_RESULT_REUSE_EN
                rs1_d = issue_rs1;
                rs2_d = issue_rs2;
                sgn_d = sgn;
                if (!dz && !ovf && c_vld_q && c_rs1_q == issue_rs1 && c_rs2_q == issue_rs2 && c_sgn_q == sgn) begin
                    state_d   = RESULT;
                    wb_data_d = fix(c_quo_q, c_rem_q, n1, n2, issue_op[1]);
                end
`endif
            end
            START: begin
                state_d = WAIT;
                done_d  = core_done;
            end
            WAIT: if (done_q) begin
                // Core results are valid the cycle after core_done.
                wb_data_d = fix(core_quotient, core_remainder, neg1_q, neg2_q, rem_q);
                state_d   = RESULT;
`ifdef DIV_RESULT_REUSE_EN
                c_rs1_d = rs1_q;
                c_rs2_d = rs2_q;
                c_sgn_d = sgn_q;
                c_quo_d = core_quotient;
                c_rem_d = core_remainder;
                c_vld_d = 1'b1;
`endif
            end else begin
                done_d = core_done;
            end
            RESULT: state_d = wb_ack ? IDLE : RESULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            dvd_clz_q <= '0;
            dvs_clz_q <= '0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            rem_q     <= 1'b0;
            done_q    <= 1'b0;
            id_q      <= '0;
            wb_data_q <= '0;
`ifdef DIV_RESULT_REUSE_EN
            rs1_q   <= '0;
            rs2_q   <= '0;
            sgn_q   <= 1'b0;
            c_rs1_q <= '0;
            c_rs2_q <= '0;
            c_sgn_q <= 1'b0;
            c_quo_q <= '0;
            c_rem_q <= '0;
            c_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            dvd_clz_q <= dvd_clz_d;
            dvs_clz_q <= dvs_clz_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            id_q      <= id_d;
            wb_data_q <= wb_data_d;
`ifdef DIV_RESULT_REUSE_EN
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            sgn_q   <= sgn_d;
            c_rs1_q <= c_rs1_d;
            c_rs2_q <= c_rs2_d;
            c_sgn_q <= c_sgn_d;
            c_quo_q <= c_quo_d;
            c_rem_q <= c_rem_d;
            c_vld_q <= c_vld_d;
`endif
        end
    end

    assign issue_ready       = state_q == IDLE;
    assign core_start        = state_q == START;
    assign wb_valid          = state_q == RESULT;
    assign core_dividend     = dvd_q;
    assign core_divisor      = dvs_q;
    assign core_dividend_CLZ = dvd_clz_q;
    assign core_divisor_CLZ  = dvs_clz_q;
    assign wb_data           = wb_data_q;
    assign wb_id             = id_q;
endmodule

// File: tb/tb_div_operand_ctrl.sv
// tb_div_operand_ctrl: randomized and directed checks of div_operand_ctrl against an arithmetic reference model.
// An emulated divider core answers core_start with a configurable latency.
module tb_div_operand_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1;
    logic         issue_valid = 1'b0, issue_ready;
    logic [W-1:0] issue_rs1 = '0, issue_rs2 = '0;
    logic [1:0]   issue_op = '0;
    logic [3:0]   issue_id = '0;
    logic         core_start, core_done = 1'b0;
    logic [W-1:0] core_dividend, core_divisor, core_quotient = '0, core_remainder = '0;
    logic [4:0]   core_dividend_CLZ, core_divisor_CLZ;
    logic         wb_valid, wb_ack = 1'b0;
    logic [W-1:0] wb_data;
    logic [3:0]   wb_id;

    always #5 clk = ~clk;

    div_operand_ctrl #(.DIV_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_op(issue_op), .issue_id(issue_id),
        .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_dividend_CLZ(core_dividend_CLZ), .core_divisor_CLZ(core_divisor_CLZ),
        .core_done(core_done), .core_quotient(core_quotient), .core_remainder(core_remainder),
        .wb_valid(wb_valid), .wb_ack(wb_ack), .wb_data(wb_data), .wb_id(wb_id)
    );

    int errs = 0, checks = 0;
    logic [W-1:0] exp_data, exp_a1, exp_a2, obs_data;
    logic [4:0]   exp_c1, exp_c2, obs_c1, obs_c2;
    logic [3:0]   exp_id;
    bit           hold_chk = 0, res_chk = 0, busy = 0, spur = 0;
    int           starts = 0, lat_cfg = 0, cnt = 0;
    bit           cvld = 0, csgn = 0;
    logic [W-1:0] crs1 = '0, crs2 = '0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] clzm(input logic [W-1:0] v);
        int n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return (n == W) ? 5'(W - 1) : 5'(n);
    endfunction

    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, b);
        logic signed [W-1:0] sa = a, sb = b;
        bit ov = (a == 32'h8000_0000) && (b == '1);
        case (op)
            2'd0: return (b == 0) ? '1 : ov ? a : W'(sa / sb);
            2'd1: return (b == 0) ? '1 : a / b;
            2'd2: return (b == 0) ? a : ov ? '0 : W'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Emulated unsigned core; results held from start until the next start.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst) busy = 0;
        else begin
            if (core_start) begin
                cnt = lat_cfg;
                busy = 1;
                core_quotient  = (core_divisor == 0) ? '1 : core_dividend / core_divisor;
                core_remainder = (core_divisor == 0) ? core_dividend : core_dividend % core_divisor;
            end
            if (busy) begin
                if (cnt == 0) begin
                    core_done = 1'b1;
                    busy = 0;
                end else cnt--;
            end else if (spur && (issue_ready || wb_valid) && $urandom_range(0, 3) == 0) core_done = 1'b1;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("ready_and_valid", {63'd0, issue_ready & wb_valid}, 0);
        if (core_start) begin
            starts++;
            obs_c1 = core_dividend_CLZ;
            obs_c2 = core_divisor_CLZ;
        end
        if (hold_chk && !wb_valid) begin
            chk("core_dividend", core_dividend, exp_a1);
            chk("core_divisor", core_divisor, exp_a2);
            chk("dividend_clz", core_dividend_CLZ, exp_c1);
            chk("divisor_clz", core_divisor_CLZ, exp_c2);
            chk("ready_busy", issue_ready, 0);
        end
        if (res_chk && wb_valid) begin
            chk("wb_data", wb_data, exp_data);
            chk("wb_id", wb_id, exp_id);
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, b, input logic [3:0] id, input int lat, ackd);
        bit sgn = !op[0];
        bit byp;
        int n = 0, t = 0;
        exp_a1 = (sgn && a[W-1]) ? -a : a;
        exp_a2 = (sgn && b[W-1]) ? -b : b;
        exp_c1 = clzm(exp_a1);
        exp_c2 = clzm(exp_a2);
        exp_data = ref_div(op, a, b);
        exp_id = id;
        byp = (b == 0) || (sgn && a == 32'h8000_0000 && b == '1);
`ifdef DIV_RESULT_REUSE_EN
        if (!byp && cvld && crs1 == a && crs2 == b && csgn == sgn) byp = 1;
`endif
        lat_cfg = lat;
        starts = 0;
        while (!issue_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_issue", issue_ready, 1);
        issue_valid = 1'b1;
        issue_op = op;
        issue_rs1 = a;
        issue_rs2 = b;
        issue_id = id;
        @(negedge clk);
        issue_valid = 1'b0;
        hold_chk = !byp;
        res_chk = 1;
        while (!wb_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        hold_chk = 0;
        chk("latency", n, byp ? 0 : 2 + lat);
        chk("start_count", starts, byp ? 0 : 1);
        obs_data = wb_data;
        repeat (ackd) @(negedge clk);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        res_chk = 0;
        chk("ready_after_ack", issue_ready, 1);
        chk("valid_after_ack", wb_valid, 0);
        if (!byp) begin
            cvld = 1;
            crs1 = a;
            crs2 = b;
            csgn = sgn;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(1, 20));
            4: return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int bad;
        logic [W-1:0] ra, rb;
        #1;
        chk("rst_ready", issue_ready, 1);
        chk("rst_valid", wb_valid, 0);
        chk("rst_start", core_start, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_id", wb_id, 0);
        chk("rst_dividend", core_dividend, 0);
        chk("rst_divisor", core_divisor, 0);
        chk("rst_clz", {core_dividend_CLZ, core_divisor_CLZ}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'd1, 100, 7, 3, 2, 1);
        chk("lit_divu_data", obs_data, 14);
        chk("lit_divu_clz1", obs_c1, 25);
        chk("lit_divu_clz2", obs_c2, 29);
        do_op(2'd2, -32'd100, 7, 4, 1, 0);
        chk("lit_rem_neg", obs_data, 32'hFFFF_FFFE);
        do_op(2'd0, -32'd100, 7, 5, 3, 0);
        chk("lit_div_neg", obs_data, 32'hFFFF_FFF2);
        do_op(2'd0, 5, 0, 6, 0, 0);
        chk("lit_div_zero", obs_data, 32'hFFFF_FFFF);
        do_op(2'd2, 32'h8000_0000, '1, 7, 0, 0);
        chk("lit_rem_ovf", obs_data, 0);
        do_op(2'd0, 32'h8000_0000, '1, 8, 0, 2);
        chk("lit_div_ovf", obs_data, 32'h8000_0000);
        do_op(2'd3, 9, 0, 9, 0, 0);
        chk("lit_remu_zero", obs_data, 9);
        do_op(2'd1, 3, 9, 10, 0, 5);
        chk("lit_divu_small", obs_data, 0);
        do_op(2'd1, 0, 1, 11, 0, 0);
        chk("lit_clz_zero", obs_c1, 31);
`ifdef DIV_RESULT_REUSE_EN
        do_op(2'd0, 100, 7, 12, 2, 0);
        do_op(2'd2, 100, 7, 13, 2, 0);
        chk("lit_reuse_rem", obs_data, 2);
`endif

        spur = 1;
        ra = '0;
        rb = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                ra = pick();
                rb = pick();
            end
            do_op(2'($urandom_range(0, 3)), ra, rb, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
        end
        spur = 0;

        lat_cfg = 20;
        issue_valid = 1'b1;
        issue_op = 2'd1;
        issue_rs1 = 1000;
        issue_rs2 = 3;
        issue_id = 4'hA;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", issue_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", issue_ready, 1);
        chk("mid_rst_valid", wb_valid, 0);
        chk("mid_rst_start", core_start, 0);
        chk("mid_rst_dividend", core_dividend, 0);
        chk("mid_rst_divisor", core_divisor, 0);
        chk("mid_rst_wb", {wb_data, 28'd0, wb_id}, 0);
        cvld = 0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (wb_valid || core_start) bad++;
        end
        chk("no_wb_after_rst", bad, 0);
        do_op(2'd3, 1000, 3, 1, 1, 0);
        chk("post_rst_op", obs_data, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
